// File: rtl/alu_mul_seq_if.sv
// Bundle of the multiply sequencer's command/status signals and its shared-ALU port.
// The slave view belongs to the sequencer; the master view belongs to whatever drives
// it (execute stage plus the ALU and its arbiter).
`timescale 1ns/1ps
interface alu_mul_seq_if;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        alu_req;
   logic        alu_gnt;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [5:0]  alu_sel;
   logic [15:0] alu_out;

   modport master (
      output start, op_a, op_b, alu_gnt, alu_out,
      input  busy, done, result, alu_req, alu_a, alu_b, alu_sel
   );

   modport slave (
      input  start, op_a, op_b, alu_gnt, alu_out,
      output busy, done, result, alu_req, alu_a, alu_b, alu_sel
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16 multiplier (low 16 bits) that borrows the shared ALU one
// operation per cycle: add into acc, shift multiplicand left, shift multiplier right.
`timescale 1ns/1ps
module alu_mul_seq #(
   parameter logic [5:0] SEL_ADD = 6'h20,
   parameter logic [5:0] SEL_SHL = 6'h16,
   parameter logic [5:0] SEL_SHR = 6'h14
) (
   input logic          clk,
   input logic          rst_n,
   alu_mul_seq_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StAdd,
      StShl,
      StShr,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] mc_q, mc_d;
   logic [15:0] mp_q, mp_d;
   logic [15:0] result_q, result_d;

   // Next-state, datapath updates and outputs; ALU operands come only from registers,
   // so alu_out never feeds back into alu_a/alu_b/alu_sel within a cycle.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mc_d        = mc_q;
      mp_d        = mp_q;
      result_d    = result_q;
      bus.busy    = 1'b0;
      bus.done    = 1'b0;
      bus.alu_req = 1'b0;
      bus.alu_a   = '0;
      bus.alu_b   = '0;
      bus.alu_sel = '0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               acc_d   = '0;
               mc_d    = bus.op_a;
               mp_d    = bus.op_b;
               state_d = StCheck;
            end
         end
         StCheck: begin
            bus.busy = 1'b1;
            if (mp_q == '0) begin
               // Capture the product on entry to DONE so it is valid with the pulse.
               result_d = acc_q;
               state_d  = StDone;
            end else if (mp_q[0]) begin
               state_d = StAdd;
            end else begin
               state_d = StShl;
            end
         end
         StAdd: begin
            bus.busy    = 1'b1;
            bus.alu_req = 1'b1;
            bus.alu_a   = acc_q;
            bus.alu_b   = mc_q;
            bus.alu_sel = SEL_ADD;
            if (bus.alu_gnt) begin
               acc_d   = bus.alu_out;
               state_d = StShl;
            end
         end
         StShl: begin
            bus.busy    = 1'b1;
            bus.alu_req = 1'b1;
            bus.alu_a   = mc_q;
            bus.alu_b   = 16'd1;
            bus.alu_sel = SEL_SHL;
            if (bus.alu_gnt) begin
               mc_d    = bus.alu_out;
               state_d = StShr;
            end
         end
         StShr: begin
            bus.busy    = 1'b1;
            bus.alu_req = 1'b1;
            bus.alu_a   = mp_q;
            bus.alu_b   = 16'd1;
            bus.alu_sel = SEL_SHR;
            if (bus.alu_gnt) begin
               mp_d    = bus.alu_out;
               state_d = StCheck;
            end
         end
         StDone: begin
            bus.done = 1'b1;
            // A start here is accepted directly, giving back-to-back operation.
            if (bus.start) begin
               acc_d   = '0;
               mc_d    = bus.op_a;
               mp_d    = bus.op_b;
               state_d = StCheck;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         mc_q     <= '0;
         mp_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mc_q     <= mc_d;
         mp_q     <= mp_d;
         result_q <= result_d;
      end
   end

   assign bus.result = result_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: directed corner cases plus random operands and random grant
// patterns, checked against plain multiplication and a bit-count latency model.
`timescale 1ns/1ps
module tb_alu_mul_seq;

   localparam logic [5:0] SEL_ADD = 6'h20;
   localparam logic [5:0] SEL_SHL = 6'h16;
   localparam logic [5:0] SEL_SHR = 6'h14;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   alu_mul_seq_if bus ();

   alu_mul_seq #(
      .SEL_ADD (SEL_ADD),
      .SEL_SHL (SEL_SHL),
      .SEL_SHR (SEL_SHR)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU model.
   always_comb begin
      case (bus.alu_sel)
         SEL_ADD: bus.alu_out = bus.alu_a + bus.alu_b;
         SEL_SHL: bus.alu_out = bus.alu_a << bus.alu_b;
         SEL_SHR: bus.alu_out = bus.alu_a >> bus.alu_b;
         default: bus.alu_out = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // One multiply. gmode: 0 gnt always high, 1 gnt low every other cycle, 2 random.
   // inj_cyc>0 pulses a stray start (7*7) in that busy cycle. pre: start already
   // driven (back-to-back). b2b: drive start with na/nb in the done cycle.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int gmode,
                         input int inj_cyc, input bit pre, input bit b2b,
                         input logic [15:0] na, input logic [15:0] nb);
      int          cyc      = 0;
      int          stalls   = 0;
      int          zero_err = 0;
      int          busy_err = 0;
      int          exp_lat;
      bit          seen     = 1'b0;
      bit          hold_v   = 1'b0;
      logic [37:0] hold     = '0;
      logic [5:0]  got_q[$];
      logic [5:0]  exp_q[$];
      logic [15:0] m;
      logic [31:0] prod;

      if (!pre) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.op_a  = a;
         bus.op_b  = b;
      end
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.op_a  = 16'($urandom);
      bus.op_b  = 16'($urandom);
      cyc = 1;
      while (!seen && cyc < 400) begin
         case (gmode)
            0:       bus.alu_gnt = 1'b1;
            1:       bus.alu_gnt = (cyc % 2) == 0;
            default: bus.alu_gnt = 1'($urandom_range(0, 1));
         endcase
         if (cyc == inj_cyc) begin
            bus.start = 1'b1;
            bus.op_a  = 16'h0007;
            bus.op_b  = 16'h0007;
         end else if (inj_cyc > 0 && cyc == inj_cyc + 1) begin
            bus.start = 1'b0;
         end
         if (hold_v) chk("alu_hold_while_stalled", {bus.alu_a, bus.alu_b, bus.alu_sel}, hold);
         if (!bus.alu_req && (bus.alu_a != 0 || bus.alu_b != 0 || bus.alu_sel != 0))
            zero_err++;
         if (bus.alu_req && bus.alu_gnt) got_q.push_back(bus.alu_sel);
         if (bus.alu_req && !bus.alu_gnt) stalls++;
         hold_v = bus.alu_req && !bus.alu_gnt;
         hold   = {bus.alu_a, bus.alu_b, bus.alu_sel};
         if (bus.done) begin
            seen = 1'b1;
         end else begin
            if (!bus.busy) busy_err++;
            @(negedge clk);
            cyc++;
         end
      end

      // Reference: one CHECK per multiplier bit up to its top one, plus start/done.
      exp_lat = 2;
      m = b;
      while (m != 0) begin
         if (m[0]) exp_q.push_back(SEL_ADD);
         exp_q.push_back(SEL_SHL);
         exp_q.push_back(SEL_SHR);
         exp_lat += m[0] ? 4 : 3;
         m = m >> 1;
      end
      prod = 32'(a) * 32'(b);

      chk("done_seen", 64'(seen), 64'd1);
      chk("done_latency", 64'(cyc), 64'(exp_lat + stalls));
      chk("result", 64'(bus.result), 64'(prod[15:0]));
      chk("busy_low_in_done", 64'(bus.busy), 64'd0);
      chk("alu_op_count", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk("alu_sel_sequence", 64'(got_q[i]), 64'(exp_q[i]));
      chk("alu_ports_zero_without_req", 64'(zero_err), 64'd0);
      chk("busy_while_running", 64'(busy_err), 64'd0);

      if (b2b) begin
         bus.start = 1'b1;
         bus.op_a  = na;
         bus.op_b  = nb;
      end else begin
         @(negedge clk);
         chk("done_single_pulse", 64'(bus.done), 64'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra, rb;
      int          bad;

      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.op_a    = '0;
      bus.op_b    = '0;
      bus.alu_gnt = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_alu_req", 64'(bus.alu_req), 64'd0);
      chk("reset_result", 64'(bus.result), 64'd0);
      chk("reset_alu_ports", {bus.alu_a, bus.alu_b, bus.alu_sel}, 64'd0);
      rst_n = 1'b1;

      run_op(16'h0003, 16'h0005, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      run_op(16'hDEAD, 16'h0000, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      run_op(16'hFFFF, 16'hFFFF, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      run_op(16'h00FE, 16'h00CA, 1, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (5) @(negedge clk);
      chk("result_held_idle", 64'(bus.result), 64'h0000_C86C);

      // Stray start while busy is ignored; then a start in the done cycle chains.
      run_op(16'h0003, 16'h0005, 0, 4, 1'b0, 1'b0, 16'h0, 16'h0);
      run_op(16'h0003, 16'h0005, 0, 0, 1'b0, 1'b1, 16'h1234, 16'h0ABC);
      run_op(16'h1234, 16'h0ABC, 2, 0, 1'b1, 1'b0, 16'h0, 16'h0);

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 3 == 0) rb = rb & 16'h00FF;
         run_op(ra, rb, 2, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      end

      // Reset in the middle of an operation.
      run_op(16'h0003, 16'h0005, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = 16'h0003;
      bus.op_b  = 16'h0005;
      @(posedge clk);
      @(negedge clk);
      bus.start   = 1'b0;
      bus.alu_gnt = 1'b1;
      repeat (5) @(negedge clk);
      chk("pre_reset_busy", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midop_reset_busy", 64'(bus.busy), 64'd0);
      chk("midop_reset_done", 64'(bus.done), 64'd0);
      chk("midop_reset_alu_req", 64'(bus.alu_req), 64'd0);
      chk("midop_reset_result", 64'(bus.result), 64'd0);
      chk("midop_reset_alu_ports", {bus.alu_a, bus.alu_b, bus.alu_sel}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy || bus.alu_req) bad++;
      end
      chk("idle_after_reset", 64'(bad), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
